bus_cycle_sequencer: RTL

//  Sequences every 65C02 bus cycle: one-clk CPU clock enable, peripheral enable, external phi2.

---
 rtl/bus_cycle_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bus_cycle_sequencer.sv
// 65C02 bus cycle sequencer: CPU/peripheral clock enables, phi2, external wait-state stretch and debug halt/step.
// Optional cycle counter enabled by defining CYCLE_COUNT_EN.
module bus_cycle_sequencer #(
  parameter int unsigned CLKEN_BITS  = 4,
  parameter int unsigned EXT_WAIT    = 4,
  parameter int unsigned MAX_STRETCH = 64
) (
  input  logic        clk,
  input  logic        resb,
  input  logic        ext_sel,
  input  logic        ext_rdy,
  input  logic        halt_req,
  input  logic        step,
  output logic        cpu_clken,
  output logic        per_clken,
  output logic        phi2,
  output logic        halted,
  output logic        bus_timeout,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned N  = 2 ** CLKEN_BITS;
  localparam int unsigned H  = N / 2;
  localparam int unsigned CW = CLKEN_BITS;
  localparam int unsigned WW = 8;

  typedef enum logic [4:0] {
    S_LO      = 5'b00001,
    S_HI      = 5'b00010,
    S_STRETCH = 5'b00100,
    S_EDGE    = 5'b01000,
    S_HALT    = 5'b10000
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [WW:0]   wcnt_inc;
  logic          ext_cycle_q, ext_cycle_d;
  logic          timeout_d;
  logic          rdy_meta, ext_rdy_s;

  assign wcnt_inc = (WW+1)'(wcnt_q) + (WW+1)'(1);

  // Two-flop synchroniser for the asynchronous external ready
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      rdy_meta  <= 1'b0;
      ext_rdy_s <= 1'b0;
    end else begin
      rdy_meta  <= ext_rdy;
      ext_rdy_s <= rdy_meta;
    end
  end

  // State register; outputs are flopped from the next state so they never glitch
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_q     <= S_LO;
      ctr_q       <= '0;
      wcnt_q      <= '0;
      ext_cycle_q <= 1'b0;
      bus_timeout <= 1'b0;
      phi2        <= 1'b0;
      cpu_clken   <= 1'b0;
      per_clken   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      wcnt_q      <= wcnt_d;
      ext_cycle_q <= ext_cycle_d;
      bus_timeout <= timeout_d;
      phi2        <= (state_d == S_HI) || (state_d == S_STRETCH) || (state_d == S_EDGE);
      cpu_clken   <= (state_d == S_EDGE);
      per_clken   <= cpu_clken;
      halted      <= (state_d == S_HALT);
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    wcnt_d      = wcnt_q;
    ext_cycle_d = ext_cycle_q;
    timeout_d   = bus_timeout;
    unique case (state_q)
      S_LO: begin
        ctr_d = ctr_q + CW'(1);
        if (ctr_q == CW'(H - 1)) begin
          state_d     = S_HI;
          ext_cycle_d = ext_sel;
        end
      end
      S_HI: begin
        ctr_d = ctr_q + CW'(1);
        if (ctr_q == CW'(N - 2)) begin
          if (ext_cycle_q && ((EXT_WAIT != 0) || !ext_rdy_s)) begin
            state_d = S_STRETCH;
            wcnt_d  = '0;
          end else begin
            state_d = S_EDGE;
          end
        end
      end
      S_STRETCH: begin
        wcnt_d = wcnt_inc[WW-1:0];
        if (wcnt_inc == (WW+1)'(MAX_STRETCH)) begin
          state_d   = S_EDGE;
          timeout_d = 1'b1;
        end else if ((wcnt_inc >= (WW+1)'(EXT_WAIT)) && ext_rdy_s) begin
          state_d = S_EDGE;
        end
      end
      S_EDGE: begin
        ctr_d   = '0;
        state_d = (halt_req && !step) ? S_HALT : S_LO;
      end
      S_HALT: begin
        ctr_d = '0;
        if (step || !halt_req) state_d = S_LO;
      end
      default: begin
        state_d = S_LO;
        ctr_d   = '0;
      end
    endcase
  end

`ifdef CYCLE_COUNT_EN
  logic [31:0] cnt_q;

  // Completed CPU cycles, wrapping
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) cnt_q <= '0;
    else if (cpu_clken) cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = 32'h0;
`endif

endmodule
